// File: rtl/sensor_scanner_n.sv
// N-channel ultrasonic ranging scanner: fires each sensor in turn, times the echo
// straight into 3-digit BCD centimetres and keeps a per-channel result bank.

module sensor_scanner_n_bcd_digit (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] d
);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)   d <= '0;
    else if (clr) d <= '0;
    else if (inc) d <= (d == 4'd9) ? 4'd0 : d + 4'd1;
  end
endmodule

module sensor_scanner_n #(
  parameter int N              = 3,
  parameter int CICLOS_TRIGGER = 500,
  parameter int CICLOS_CM      = 2941,
  parameter int ESPERA_ECO     = 1_500_000,
  parameter int INTERVALO      = 3_000_000,
  parameter int MAX_CM         = 400
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          iniciar,
  input  logic          continuo,
  input  logic [N-1:0]  echo,
  input  logic [2:0]    sel,
  output logic [N-1:0]  trigger,
  output logic [11:0]   distancia,
  output logic [N-1:0]  valido,
  output logic [N-1:0]  erro,
  output logic          pronto,
  output logic [3:0]    db_estado,
  output logic [3:0]    db_sensor
);
  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  localparam logic [11:0] BCD_MAX = to_bcd(MAX_CM);
  localparam logic [11:0] BCD_OVR = to_bcd(MAX_CM + 1);

  typedef enum logic [3:0] {
    S_INI = 4'd0, S_PREP = 4'd1, S_TRIG = 4'd2, S_ESP = 4'd3,
    S_MEDE = 4'd4, S_ARM = 4'd5, S_INT = 4'd6, S_FIM = 4'd7
  } st_t;

  st_t                  state, nx;
  logic [31:0]          tmr;
  logic [2:0]           canal;
  logic [N-1:0]         e_m, e_s;
  logic                 ech, armed, to_f, ov_f, inc;
  logic [2:0][3:0]      bcd;
  logic [2:0]           inc_c;
  logic [N-1:0][11:0]   bank;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      e_m <= '0;
      e_s <= '0;
    end else begin
      e_m <= echo;
      e_s <= e_m;
    end
  end

  always_comb begin
    ech = 1'b0;
    for (int i = 0; i < N; i++)
      if (canal == 3'(i)) ech = e_s[i];
  end

  // one cm tick per CICLOS_CM clocks of echo; the timer wraps only inside MEDE
  assign inc      = (state == S_MEDE) && ech && (tmr == 32'(CICLOS_CM - 1));
  assign inc_c[0] = inc;
  for (genvar i = 0; i < 2; i++) begin : g_carry
    assign inc_c[i+1] = inc_c[i] && (bcd[i] == 4'd9);
  end
  for (genvar i = 0; i < 3; i++) begin : g_dig
    sensor_scanner_n_bcd_digit u_dig (
      .clock(clock), .reset(reset), .clr(state == S_PREP), .inc(inc_c[i]), .d(bcd[i])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_INI;
    else        state <= nx;
  end

  always_comb begin
    nx = state;
    case (state)
      S_INI:  if (iniciar) nx = S_PREP;
      S_PREP: nx = S_TRIG;
      S_TRIG: if (tmr == 32'(CICLOS_TRIGGER - 1)) nx = S_ESP;
      S_ESP:  if (armed && ech) nx = S_MEDE;
              else if (tmr == 32'(ESPERA_ECO - 1)) nx = S_ARM;
      S_MEDE: if (!ech || bcd == BCD_OVR) nx = S_ARM;
      S_ARM:  nx = S_INT;
      S_INT:  if (tmr == 32'(INTERVALO - 1)) nx = (canal == 3'(N - 1)) ? S_FIM : S_PREP;
      S_FIM:  nx = continuo ? S_PREP : S_INI;
      default: nx = S_INI;
    endcase
  end

  always_comb begin
    trigger = '0;
    for (int i = 0; i < N; i++)
      trigger[i] = (state == S_TRIG) && (canal == 3'(i));
    distancia = '0;
    for (int i = 0; i < N; i++)
      if (sel == 3'(i)) distancia = bank[i];
    pronto    = (state == S_FIM);
    db_estado = state;
    db_sensor = {1'b0, canal};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmr   <= '0;
      canal <= '0;
      armed <= 1'b0;
      to_f  <= 1'b0;
      ov_f  <= 1'b0;
    end else begin
      if (state == S_INI || state != nx)                        tmr <= '0;
      else if (state == S_MEDE && tmr == 32'(CICLOS_CM - 1))    tmr <= '0;
      else                                                      tmr <= tmr + 32'd1;

      if ((state == S_INI || state == S_FIM) && nx == S_PREP)   canal <= '0;
      else if (state == S_INT && nx == S_PREP)                  canal <= canal + 3'd1;

      // echo already high on entry is not a rise: it must be seen low first
      if (state == S_PREP)                 armed <= 1'b0;
      else if (state == S_ESP && !ech)     armed <= 1'b1;

      if (state == S_PREP)                       to_f <= 1'b0;
      else if (state == S_ESP && nx == S_ARM)    to_f <= 1'b1;

      if (state == S_PREP)                              ov_f <= 1'b0;
      else if (state == S_MEDE && ech && nx == S_ARM)   ov_f <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bank   <= '0;
      valido <= '0;
      erro   <= '0;
    end else if (state == S_ARM) begin
      for (int i = 0; i < N; i++) begin
        if (canal == 3'(i)) begin
          if (to_f) begin
            valido[i] <= 1'b0;
            erro[i]   <= 1'b1;
          end else if (ov_f) begin
            bank[i]   <= BCD_MAX;
            valido[i] <= 1'b0;
            erro[i]   <= 1'b1;
          end else begin
            bank[i]   <= bcd;
            valido[i] <= 1'b1;
            erro[i]   <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_sensor_scanner_n.sv
// Bench for sensor_scanner_n: sensor echo responders, a cycle monitor and
// scenario tasks checked against readings derived from the echo lengths.

module tb_sensor_scanner_n;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          ini0, cont0, ini1, cont1;
  logic [N-1:0]  echo0, echo1;
  logic [2:0]    sel0, sel1;
  logic [N-1:0]  trig0, val0, err0, trig1, val1, err1;
  logic [11:0]   dist0, dist1;
  logic          pr0, pr1;
  logic [3:0]    st0, sn0, st1, sn1;

  sensor_scanner_n #(.N(N), .CICLOS_TRIGGER(4), .CICLOS_CM(10), .ESPERA_ECO(100),
                     .INTERVALO(20), .MAX_CM(20)) u0 (
    .clock(clk), .reset(rst_n), .iniciar(ini0), .continuo(cont0), .echo(echo0),
    .sel(sel0), .trigger(trig0), .distancia(dist0), .valido(val0), .erro(err0),
    .pronto(pr0), .db_estado(st0), .db_sensor(sn0));

  sensor_scanner_n #(.N(N), .CICLOS_TRIGGER(4), .CICLOS_CM(10), .ESPERA_ECO(100),
                     .INTERVALO(20), .MAX_CM(200)) u1 (
    .clock(clk), .reset(rst_n), .iniciar(ini1), .continuo(cont1), .echo(echo1),
    .sel(sel1), .trigger(trig1), .distancia(dist1), .valido(val1), .erro(err1),
    .pronto(pr1), .db_estado(st1), .db_sensor(sn1));

  int elen0 [N];
  int elen1 [N];

  // each sensor answers 5 cycles after its trigger falls; length 0 = never answers
  for (genvar g = 0; g < N; g++) begin : g_rsp
    logic e0 = 1'b0, e1 = 1'b0;
    assign echo0[g] = e0;
    assign echo1[g] = e1;
    initial forever begin
      @(negedge trig0[g]);
      if (elen0[g] > 0) begin
        repeat (5) @(posedge clk); #1 e0 = 1'b1;
        repeat (elen0[g]) @(posedge clk); #1 e0 = 1'b0;
      end
    end
    initial forever begin
      @(negedge trig1[g]);
      if (elen1[g] > 0) begin
        repeat (5) @(posedge clk); #1 e1 = 1'b1;
        repeat (elen1[g]) @(posedge clk); #1 e1 = 1'b0;
      end
    end
  end

  int cyc, pr_cnt, pr1_cnt, oh_err, esp_run, prev_st, prev_sn;
  int tw [N];
  int esp_last [N];
  bit mede_echo [N];
  int tq_ch[$], tq_w[$], pr_t[$];

  initial begin
    cyc = 0; pr_cnt = 0; pr1_cnt = 0; oh_err = 0; esp_run = 0; prev_st = 0; prev_sn = 0;
    for (int i = 0; i < N; i++) begin tw[i] = 0; esp_last[i] = 0; mede_echo[i] = 0; end
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N; i++) begin
      if (trig0[i]) tw[i] <= tw[i] + 1;
      else if (tw[i] > 0) begin tq_ch.push_back(i); tq_w.push_back(tw[i]); tw[i] <= 0; end
    end
    if ($countones(trig0) > 1) oh_err <= oh_err + 1;
    if (pr0) begin pr_cnt <= pr_cnt + 1; pr_t.push_back(cyc); end
    if (pr1) pr1_cnt <= pr1_cnt + 1;
    if (st0 == 4'd3) esp_run <= esp_run + 1;
    else begin
      if (prev_st == 3) esp_last[prev_sn] <= esp_run;
      esp_run <= 0;
    end
    if (prev_st == 4 && st0 == 4'd5) mede_echo[sn0] <= echo0[sn0];
    prev_st <= int'(st0);
    prev_sn <= int'(sn0);
  end

  int pass_cnt = 0, tot_cnt = 0;

  function automatic int bcd2int(input logic [11:0] b);
    if (b[11:8] > 9 || b[7:4] > 9 || b[3:0] > 9) return -1;
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic wait_pr0(input int budget, output bit ok);
    int s;
    s = pr_cnt; ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pr_cnt > s) begin ok = 1; break; end
    end
  endtask

  task automatic scan0(input int budget, output bit ok);
    @(negedge clk); ini0 = 1'b1;
    @(negedge clk); ini0 = 1'b0;
    wait_pr0(budget, ok);
    repeat (3) @(negedge clk);
  endtask

  task automatic read0(input int ch, output logic [11:0] v);
    sel0 = 3'(ch); #1 v = dist0;
  endtask

  task automatic test_reset;
    logic [11:0] v;
    @(negedge clk);
    tot_cnt++; if (trig0 !== 3'b000) $display("FAIL reset_trigger: got %b want 000", trig0); else pass_cnt++;
    tot_cnt++; if (val0 !== 3'b000 || err0 !== 3'b000) $display("FAIL reset_flags: got v=%b e=%b want 0", val0, err0); else pass_cnt++;
    tot_cnt++; if (pr0 !== 1'b0 || st0 !== 4'd0 || sn0 !== 4'd0) $display("FAIL reset_state: got p=%b st=%0d sn=%0d want 0", pr0, st0, sn0); else pass_cnt++;
    for (int c = 0; c < N; c++) begin
      read0(c, v);
      tot_cnt++; if (v !== 12'h000) $display("FAIL reset_bank%0d: got %h want 000", c, v); else pass_cnt++;
    end
  endtask

  task automatic check_bank(input string nm, input int len [N]);
    logic [11:0] v;
    int got, want;
    for (int c = 0; c < N; c++) begin
      read0(c, v);
      got = bcd2int(v); want = len[c] / 10;
      tot_cnt++;
      if (got < 0 || iabs(got - want) > 1) $display("FAIL %s_bank%0d: got %h want %0d +-1", nm, c, v, want);
      else pass_cnt++;
    end
  endtask

  task automatic test_basic;
    bit ok;
    int qi, s, oh;
    qi = tq_ch.size(); s = pr_cnt; oh = oh_err;
    elen0[0] = 125; elen0[1] = 57; elen0[2] = 200;
    scan0(3000, ok);
    tot_cnt++; if (!ok) $display("FAIL basic_pronto: got none want 1 within budget"); else pass_cnt++;
    tot_cnt++; if (tq_ch.size() - qi != 3) $display("FAIL basic_trig_count: got %0d want 3", tq_ch.size() - qi); else pass_cnt++;
    for (int k = 0; k < 3 && qi + k < tq_ch.size(); k++) begin
      tot_cnt++;
      if (tq_ch[qi+k] != k || tq_w[qi+k] != 4) $display("FAIL basic_trig%0d: got ch=%0d w=%0d want ch=%0d w=4", k, tq_ch[qi+k], tq_w[qi+k], k);
      else pass_cnt++;
    end
    tot_cnt++; if (oh_err != oh) $display("FAIL basic_onehot: got %0d violations want 0", oh_err - oh); else pass_cnt++;
    check_bank("basic", elen0);
    tot_cnt++; if (val0 !== 3'b111 || err0 !== 3'b000) $display("FAIL basic_flags: got v=%b e=%b want 111/000", val0, err0); else pass_cnt++;
    tot_cnt++; if (pr_cnt - s != 1 || st0 !== 4'd0) $display("FAIL basic_one_pronto: got %0d st=%0d want 1 st=0", pr_cnt - s, st0); else pass_cnt++;
  endtask

  task automatic test_random;
    bit ok;
    for (int it = 0; it < 2; it++) begin
      for (int c = 0; c < N; c++) elen0[c] = int'($urandom_range(185, 15));
      scan0(3000, ok);
      tot_cnt++; if (!ok) $display("FAIL rand%0d_pronto: got none want 1", it); else pass_cnt++;
      check_bank("rand", elen0);
      tot_cnt++; if (val0 !== 3'b111 || err0 !== 3'b000) $display("FAIL rand%0d_flags: got v=%b e=%b want 111/000", it, val0, err0); else pass_cnt++;
    end
  endtask

  task automatic test_timeout;
    bit ok;
    logic [11:0] prev, v;
    read0(1, prev);
    elen0[0] = 60; elen0[1] = 0; elen0[2] = 60;
    scan0(3000, ok);
    tot_cnt++; if (!ok) $display("FAIL timeout_pronto: got none want 1"); else pass_cnt++;
    tot_cnt++; if (err0 !== 3'b010 || val0 !== 3'b101) $display("FAIL timeout_flags: got e=%b v=%b want 010/101", err0, val0); else pass_cnt++;
    read0(1, v);
    tot_cnt++; if (v !== prev) $display("FAIL timeout_bank_kept: got %h want %h", v, prev); else pass_cnt++;
    tot_cnt++; if (esp_last[1] != 100) $display("FAIL timeout_wait_len: got %0d want 100", esp_last[1]); else pass_cnt++;
  endtask

  task automatic test_overrange;
    bit ok;
    logic [11:0] v;
    elen0[0] = 60; elen0[1] = 60; elen0[2] = 500;
    scan0(3000, ok);
    tot_cnt++; if (!ok) $display("FAIL ovr_pronto: got none want 1"); else pass_cnt++;
    read0(2, v);
    tot_cnt++; if (v !== 12'h020) $display("FAIL ovr_bank: got %h want 020", v); else pass_cnt++;
    tot_cnt++; if (err0 !== 3'b100 || val0 !== 3'b011) $display("FAIL ovr_flags: got e=%b v=%b want 100/011", err0, val0); else pass_cnt++;
    tot_cnt++; if (mede_echo[2] !== 1'b1) $display("FAIL ovr_early_exit: got echo=%b at exit want 1", mede_echo[2]); else pass_cnt++;
    repeat (400) @(negedge clk);
  endtask

  task automatic test_continuous;
    bit ok;
    int pi, p1, p2, s, formula;
    elen0[0] = 40; elen0[1] = 40; elen0[2] = 40;
    formula = N * (2 + 4 + 5 + 40 + 20) + 2;
    pi = pr_t.size();
    cont0 = 1'b1;
    @(negedge clk); ini0 = 1'b1;
    @(negedge clk); ini0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_pr0(3000, ok);
      tot_cnt++; if (!ok) $display("FAIL cont_pronto%0d: got none want pulse", k); else pass_cnt++;
    end
    if (pr_t.size() - pi >= 3) begin
      p1 = pr_t[pi+1] - pr_t[pi]; p2 = pr_t[pi+2] - pr_t[pi+1];
      tot_cnt++; if (p1 != p2) $display("FAIL cont_period_stable: got %0d then %0d want equal", p1, p2); else pass_cnt++;
      tot_cnt++; if (iabs(p1 - formula) > 5 * N) $display("FAIL cont_period: got %0d want %0d +-%0d", p1, formula, 5 * N); else pass_cnt++;
    end
    repeat (50) @(negedge clk);
    cont0 = 1'b0;
    s = pr_cnt;
    wait_pr0(3000, ok);
    repeat (2) @(negedge clk);
    tot_cnt++; if (st0 !== 4'd0) $display("FAIL cont_stop_state: got %0d want 0", st0); else pass_cnt++;
    repeat (1500) @(negedge clk);
    tot_cnt++; if (pr_cnt - s != 1) $display("FAIL cont_last_scan: got %0d prontos want 1", pr_cnt - s); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    bit found;
    int s;
    logic [11:0] v;
    elen0[0] = 40; elen0[1] = 40; elen0[2] = 40;
    found = 0;
    @(negedge clk); ini0 = 1'b1;
    @(negedge clk); ini0 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (st0 == 4'd2 && sn0 == 4'd1) begin found = 1; break; end
    end
    tot_cnt++; if (!found) $display("FAIL rstmid_reach: got no TRIGGER of ch1 want reached"); else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    tot_cnt++; if (trig0 !== 3'b000) $display("FAIL rstmid_trigger: got %b want 000", trig0); else pass_cnt++;
    tot_cnt++; if (val0 !== 3'b000 || err0 !== 3'b000 || st0 !== 4'd0) $display("FAIL rstmid_flags: got v=%b e=%b st=%0d want 0", val0, err0, st0); else pass_cnt++;
    for (int c = 0; c < N; c++) begin
      read0(c, v);
      tot_cnt++; if (v !== 12'h000) $display("FAIL rstmid_bank%0d: got %h want 000", c, v); else pass_cnt++;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s = pr_cnt;
    repeat (2500) @(negedge clk);
    tot_cnt++; if (pr_cnt != s || st0 !== 4'd0) $display("FAIL rstmid_idle: got %0d prontos st=%0d want 0 st=0", pr_cnt - s, st0); else pass_cnt++;
  endtask

  task automatic test_carry;
    bit ok;
    int s, got;
    logic [11:0] v;
    elen1[0] = 990; elen1[1] = 30; elen1[2] = 30;
    s = pr1_cnt; ok = 0;
    @(negedge clk); ini1 = 1'b1;
    @(negedge clk); ini1 = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (pr1_cnt > s) begin ok = 1; break; end
    end
    tot_cnt++; if (!ok) $display("FAIL carry_pronto: got none want 1"); else pass_cnt++;
    sel1 = 3'd0; #1 v = dist1; got = bcd2int(v);
    tot_cnt++; if (got < 0 || iabs(got - 99) > 1) $display("FAIL carry_reading: got %h want 099 +-1", v); else pass_cnt++;
    tot_cnt++; if (val1 !== 3'b111) $display("FAIL carry_valid: got %b want 111", val1); else pass_cnt++;
    sel1 = 3'd5; #1;
    tot_cnt++; if (dist1 !== 12'h000) $display("FAIL sel5_zero: got %h want 000", dist1); else pass_cnt++;
    sel1 = 3'd7; #1;
    tot_cnt++; if (dist1 !== 12'h000) $display("FAIL sel7_zero: got %h want 000", dist1); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; ini0 = 1'b0; cont0 = 1'b0; ini1 = 1'b0; cont1 = 1'b0;
    sel0 = 3'd0; sel1 = 3'd0;
    for (int i = 0; i < N; i++) begin elen0[i] = 0; elen1[i] = 0; end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset;
    test_basic;
    test_random;
    test_timeout;
    test_overrange;
    test_continuous;
    test_reset_mid;
    test_carry;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
